// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the pixel sorting datapath.
package sort_pkg;

   localparam int unsigned DATA_W        = 16;
   localparam int unsigned DEPTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      LOAD,
      SORT,
      DRAIN
   } state_t;

   // Width of a counter that must hold the values 0..depth inclusive.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/compare16.sv
// Unsigned 16-bit magnitude comparator.
module compare16 (
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic        Abigger,
   output logic        Bbigger,
   output logic        Equal
);

   assign Abigger = (A > B);
   assign Bbigger = (A < B);
   assign Equal   = (A == B);

endmodule

// File: rtl/pixel_bubble_sorter.sv
// Buffers one frame of pixel keys, bubble-sorts it in place (stable, one
// compare per cycle) and streams the sorted keys out.
module pixel_bubble_sorter
   import sort_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              len_err
);

   localparam int unsigned  W         = cnt_w(DEPTH);
   localparam int unsigned  AW        = $clog2(DEPTH);
   localparam logic [W-1:0] LAST_SLOT = W'(DEPTH - 1);
   localparam logic [W-1:0] TWO       = W'(2);

   state_t state, state_next;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [W-1:0]      n;
   logic [W-1:0]      i;
   logic [W-1:0]      pass;
   logic [W-1:0]      rd;
   logic              swapped;

   logic [AW-1:0]     idx;
   logic [AW-1:0]     idx1;
   logic [DATA_W-1:0] key_a;
   logic [DATA_W-1:0] key_b;
   logic              a_bigger;
   logic              unused_b_bigger;
   logic              unused_equal;

   logic load_acc;
   logic frame_end;
   logic at_depth;
   logic pass_end;
   logic sort_done;
   logic swapped_now;
   logic drain_acc;

   // i never exceeds DEPTH-2, so the low AW bits address both neighbours.
   assign idx   = i[AW-1:0];
   assign idx1  = idx + 1'b1;
   assign key_a = mem[idx];
   assign key_b = mem[idx1];

   compare16 u_cmp (
      .A       (key_a),
      .B       (key_b),
      .Abigger (a_bigger),
      .Bbigger (unused_b_bigger),
      .Equal   (unused_equal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_next;
   end

   always_comb begin
      state_next  = state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_data    = '0;
      out_last    = 1'b0;
      busy        = 1'b0;
      load_acc    = 1'b0;
      frame_end   = 1'b0;
      sort_done   = 1'b0;
      drain_acc   = 1'b0;
      at_depth    = (n == LAST_SLOT);
      pass_end    = (i == n - TWO);
      swapped_now = swapped | a_bigger;
      case (state)
         LOAD: begin
            in_ready  = 1'b1;
            load_acc  = in_valid;
            frame_end = in_valid && (in_last || at_depth);
            if (frame_end) state_next = (n == '0) ? DRAIN : SORT;
         end
         SORT: begin
            busy      = 1'b1;
            sort_done = pass_end && (!swapped_now || (pass == n - TWO));
            if (sort_done) state_next = DRAIN;
         end
         DRAIN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_data  = mem[rd[AW-1:0]];
            out_last  = (rd == n - 1'b1);
            drain_acc = out_ready;
            if (out_ready && out_last) state_next = LOAD;
         end
         default: state_next = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n       <= '0;
         i       <= '0;
         pass    <= '0;
         rd      <= '0;
         swapped <= 1'b0;
         len_err <= 1'b0;
      end else begin
         len_err <= load_acc && at_depth && !in_last;
         case (state)
            LOAD: begin
               if (load_acc) begin
                  n       <= n + 1'b1;
                  i       <= '0;
                  pass    <= '0;
                  rd      <= '0;
                  swapped <= 1'b0;
               end
            end
            SORT: begin
               if (pass_end) begin
                  if (!sort_done) begin
                     i       <= '0;
                     pass    <= pass + 1'b1;
                     swapped <= 1'b0;
                  end
               end else begin
                  i       <= i + 1'b1;
                  swapped <= swapped_now;
               end
            end
            DRAIN: begin
               if (drain_acc) begin
                  if (out_last) begin
                     n  <= '0;
                     rd <= '0;
                  end else begin
                     rd <= rd + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Storage is left unreset: a reset discards the frame anyway.
   always_ff @(posedge clk) begin
      if (state == LOAD && load_acc) begin
         mem[n[AW-1:0]] <= in_data;
      end else if (state == SORT && a_bigger) begin
         mem[idx]  <= key_b;
         mem[idx1] <= key_a;
      end
   end

endmodule

// File: tb/tb_pixel_bubble_sorter.sv
// Self-checking bench for pixel_bubble_sorter against a stable-sort frame model.
module tb_pixel_bubble_sorter;
   import sort_pkg::*;

   localparam int unsigned DEPTH = 16;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        in_valid  = 1'b0;
   logic        in_last   = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] in_data   = '0;
   logic        in_ready;
   logic        out_valid;
   logic        out_last;
   logic        busy;
   logic        len_err;
   logic [15:0] out_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] key;
      int          tag;
      bit          last;
   } ent_t;

   ent_t exp_q[$];
   ent_t frame_buf[$];
   int   tag_ctr      = 0;
   int   exp_len_err  = 0;
   int   len_err_seen = 0;
   int   sc_q[$];
   int   sort_cnt     = 0;
   bit   prev_valid   = 1'b0;

   always #5 clk = ~clk;

   pixel_bubble_sorter #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .len_err   (len_err)
   );

   task automatic check(input string name, input int unsigned act, input int unsigned req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Insertion sort: an equal key never moves ahead of an earlier arrival.
   function automatic void stable_sort(input ent_t src[$], output ent_t dst[$]);
      dst = {};
      foreach (src[k]) begin
         int p;
         p = dst.size();
         while (p > 0 && dst[p-1].key > src[k].key) p--;
         dst.insert(p, src[k]);
      end
   endfunction

   function automatic ent_t make_ent(input logic [15:0] key, input int tag);
      ent_t e;
      e.key  = key;
      e.tag  = tag;
      e.last = 1'b0;
      return e;
   endfunction

   task automatic model_accept(input logic [15:0] key, input logic last);
      ent_t sorted[$];
      frame_buf.push_back(make_ent(key, tag_ctr));
      tag_ctr++;
      if (last || frame_buf.size() == DEPTH) begin
         if (!last) exp_len_err++;
         stable_sort(frame_buf, sorted);
         sorted[sorted.size()-1].last = 1'b1;
         foreach (sorted[k]) exp_q.push_back(sorted[k]);
         frame_buf.delete();
         tag_ctr = 0;
      end
   endtask

   task automatic send(input logic [15:0] key, input logic last);
      int c;
      in_valid = 1'b1;
      in_data  = key;
      in_last  = last;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!in_ready && c < 2000);
      if (!in_ready) begin
         check("send_timeout", 32'(in_ready), 1);
         in_valid = 1'b0;
         in_last  = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      model_accept(key, last);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain(input bit stall);
      int c;
      c = 0;
      while (exp_q.size() == 0 && c < 500) begin
         @(posedge clk);
         #1;
         c++;
      end
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      for (c = 0; c < 4000 && exp_q.size() != 0; c++) begin
         @(posedge clk);
         #1;
         out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 0);
      out_ready = 1'b0;
   endtask

   task automatic check_sc(input string name, input int req);
      if (sc_q.size() == 0) check({name, "_missing"}, 32'(sc_q.size()), 1);
      else                  check(name, 32'(sc_q.pop_front()), 32'(req));
   endtask

   // Single compare process: output stream, idle values, ready/busy relation.
   always @(negedge clk) begin
      if (rst) begin
         sort_cnt   = 0;
         prev_valid = 1'b0;
      end else begin
         check("in_ready_vs_busy", 32'(in_ready), 32'(!busy));
         if (len_err) len_err_seen++;
         if (busy && !out_valid) sort_cnt++;
         if (out_valid && !prev_valid) begin
            sc_q.push_back(sort_cnt);
            sort_cnt = 0;
         end
         prev_valid = out_valid;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("out_valid_unexpected", 32'(out_valid), 0);
            end else begin
               check("out_data", 32'(out_data), 32'(exp_q[0].key));
               check("out_last", 32'(out_last), 32'(exp_q[0].last));
               if (out_ready) void'(exp_q.pop_front());
            end
         end else begin
            check("idle_out_data", 32'(out_data), 0);
            check("idle_out_last", 32'(out_last), 0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ent_t        src[$];
      ent_t        dst[$];
      logic [15:0] tie_keys [4] = '{16'd5, 16'd3, 16'd5, 16'd3};
      logic [15:0] tie_exp  [4] = '{16'd3, 16'd3, 16'd5, 16'd5};
      int          tie_tags [4] = '{1, 3, 0, 2};
      logic [15:0] rev_keys [4] = '{16'hFFFF, 16'h8000, 16'h0100, 16'h0001};
      logic [15:0] rev_exp  [4] = '{16'h0001, 16'h0100, 16'h8000, 16'hFFFF};

      // Pin the model with hand-computed results.
      src = {};
      for (int k = 0; k < 4; k++) src.push_back(make_ent(tie_keys[k], k));
      stable_sort(src, dst);
      for (int k = 0; k < 4; k++) begin
         check("model_tie_key", 32'(dst[k].key), 32'(tie_exp[k]));
         check("model_tie_tag", 32'(dst[k].tag), 32'(tie_tags[k]));
      end
      src = {};
      for (int k = 0; k < 4; k++) src.push_back(make_ent(rev_keys[k], k));
      stable_sort(src, dst);
      for (int k = 0; k < 4; k++) check("model_rev_key", 32'(dst[k].key), 32'(rev_exp[k]));

      // Reset values while reset is held.
      #1;
      check("rst_in_ready",  32'(in_ready),  1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data",  32'(out_data),  0);
      check("rst_out_last",  32'(out_last),  0);
      check("rst_busy",      32'(busy),      0);
      check("rst_len_err",   32'(len_err),   0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Already sorted: no swaps, n-1 compare cycles.
      for (int k = 1; k <= 4; k++) send(16'(k), k == 4);
      drain(1'b0);
      check_sc("sorted_sort_cycles", 3);

      // Reverse order with downstream stalls: worst case (n-1)^2.
      for (int k = 0; k < 4; k++) send(rev_keys[k], k == 3);
      drain(1'b1);
      check_sc("reverse_sort_cycles", 9);

      // Ties.
      for (int k = 0; k < 4; k++) send(tie_keys[k], k == 3);
      drain(1'b0);
      check_sc("ties_sort_cycles", 9);

      // 17 keys without in_last: truncation at DEPTH, 17th opens the next frame.
      for (int k = 0; k < 16; k++) send(16'(k * 40503 + 12345), 1'b0);
      fork
         send(16'hABCD, 1'b1);
         drain(1'b0);
      join
      drain(1'b0);
      check("trunc_frame_count", 32'(sc_q.size()), 2);
      if (sc_q.size() > 0) void'(sc_q.pop_front());
      check_sc("next_frame_sort_cycles", 0);
      check("len_err_after_trunc", 32'(len_err_seen), 32'(exp_len_err));

      // Single key, random stalls.
      send(16'h1234, 1'b1);
      drain(1'b1);
      check_sc("single_sort_cycles", 0);

      // Reset in the middle of a long sort.
      for (int k = 0; k < 8; k++) send(16'(8 - k), k == 7);
      repeat (5) @(posedge clk);
      #1;
      check("busy_before_rst", 32'(busy), 1);
      rst = 1'b1;
      #1;
      check("midrst_in_ready",  32'(in_ready),  1);
      check("midrst_out_valid", 32'(out_valid), 0);
      check("midrst_out_data",  32'(out_data),  0);
      check("midrst_out_last",  32'(out_last),  0);
      check("midrst_busy",      32'(busy),      0);
      check("midrst_len_err",   32'(len_err),   0);
      exp_q.delete();
      frame_buf.delete();
      tag_ctr = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sc_q.delete();
      send(16'd9, 1'b0);
      send(16'd7, 1'b1);
      drain(1'b0);
      check_sc("post_rst_sort_cycles", 1);

      repeat (3) @(posedge clk);
      check("len_err_total", 32'(len_err_seen), 32'(exp_len_err));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
